seat_alloc: RTL
===============

Name: seat_alloc

Overview:
- Controller that sequences writes into the 32-entry seat memory (25-bit student number per 5-bit seat).
- Accepts seat-assignment and seat-release requests, arbitrates between them, and picks a seat (preferred seat, else lowest free).
- Drives the memory write port and keeps the authoritative 32-bit occupancy map and free-seat count.
- Sits between the front-end request logic and the seat memory instance.

Parameters:
- NUM_SEATS, 32, number of seats; must equal 2**SEAT_W.
- SEAT_W, 5, seat index width.
- STU_W, 25, student number width; value 0 is reserved as the "empty" marker.

Ports:
- clk_alloc  in  1  clock; all state changes on the rising edge.
- rst_alloc  in  1  synchronous reset, active-high.
- req_alloc  in  1  assignment request; held high until accepted.
- Student_No_alloc  in  STU_W  student number for the assignment.
- pref_en_alloc  in  1  preferred seat valid.
- pref_seat_alloc  in  SEAT_W  preferred seat index.
- rel_alloc  in  1  release request; held high until accepted.
- rel_seat_alloc  in  SEAT_W  seat to release.
- busy_alloc  out  1  high from the cycle after acceptance until the cycle after DONE.
- done_alloc  out  1  one-cycle completion pulse.
- fail_alloc  out  1  valid with done_alloc; 1 means the operation was rejected.
- Seat_No_out_alloc  out  SEAT_W  seat assigned or released; valid with done_alloc.
- write_mem_alloc  out  1  memory write strobe.
- Student_No_mem_alloc  out  STU_W  memory write data.
- Seat_No_mem_alloc  out  SEAT_W  memory write address.
- occupied_alloc  out  NUM_SEATS  occupancy map; bit i=1 means seat i is taken.
- free_cnt_alloc  out  SEAT_W+1  number of free seats, 0..32.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state=IDLE, occupied_alloc=0, free_cnt_alloc=32.
  - All other outputs 0, including busy, done, fail, write_mem, Seat_No_out, Student_No_mem, Seat_No_mem.
  - Reset mid-operation aborts it with no write and no done.
  - Seat memory contents are not cleared by reset; the occupancy map is authoritative.
- Handshake:
  - A request is accepted on a rising edge where state=IDLE and (rel_alloc or req_alloc)=1.
  - Operands are latched at acceptance.
  - The requester drops its request in the cycle after it sees busy_alloc=1.
- Arbitration: if rel_alloc and req_alloc are both high in IDLE, the release is accepted. The assignment stays pending and is accepted at the next IDLE cycle.
- States: IDLE -> CHECK -> WRITE -> DONE -> IDLE.
  - CHECK, release:
    - Seat free -> fail, skip to DONE.
    - Otherwise -> WRITE with data=0.
  - CHECK, assignment:
    - Latched student number is 0, or free_cnt=0 -> fail, skip to DONE.
    - Otherwise: if pref_en and the preferred seat is free, use it; else use the lowest-index free seat (priority encoder). Then -> WRITE.
  - WRITE:
    - write_mem_alloc=1 for exactly one cycle.
    - Seat_No_mem/Student_No_mem driven from the latched values.
    - occupied bit set (assign) or cleared (release) at the end of the cycle.
    - free_cnt decremented (assign) or incremented (release).
  - DONE:
    - done_alloc=1 for one cycle; fail_alloc and Seat_No_out_alloc valid.
    - Seat_No_mem/Student_No_mem held stable from WRITE.
    - On a fail path Seat_No_out = the requested or preferred seat (0 if none).
- Latency:
  - Acceptance at edge T: successful operation has write_mem in cycle T+2 and done in T+3.
  - Fail path has done in T+2 and no write.
  - Back-to-back: a held request is accepted at the first edge after DONE (state returns to IDLE), giving a 4-cycle throughput.
- write_mem_alloc is never high outside WRITE.
- Seat_No_out, Student_No_mem and Seat_No_mem retain their last values between operations.
- free_cnt_alloc always equals the number of zeros in occupied_alloc.
- Duplicate student numbers are not checked.

Test Plan:
- Reset, then assign student 25'd1001, no preference -> write_mem at T+2 with seat 0 and data 1001; done at T+3 with seat 0, fail=0; occupied=32'h1, free_cnt=31.
- Assign with seat 7 preferred and free -> seat 7; with seat 7 preferred and already taken (seats 0 and 7 occupied) -> lowest free seat 1.
- Fill all 32 seats, then one more assignment -> done at T+2, fail=1, no write_mem, free_cnt stays 0.
- Release seat 7 while occupied -> write seat 7 with data 0, bit 7 cleared, free_cnt+1; release seat 7 again -> fail=1, no write.
- req and rel asserted in the same IDLE cycle -> release is served first, then the assignment is accepted right after DONE, with exactly two done pulses; an assignment with Student_No=0 -> fail=1.
- Assert rst_alloc during WRITE -> next cycle all outputs 0, occupied=0, free_cnt=32, no done pulse.

Source files
------------

// File: rtl/seat_alloc.sv
// seat_alloc: sequences writes into the 32-entry seat memory.
// Accepts seat-assignment (req_alloc) and seat-release (rel_alloc) requests.
// A release wins when both are pending. The controller picks a seat and drives
// the memory write port. It also owns the authoritative occupancy map and the
// free-seat count.
//
// Ports:
//   clk_alloc, rst_alloc         clock, synchronous active-high reset
//   req_alloc, Student_No_alloc  assignment request and student number
//   pref_en_alloc, pref_seat_alloc  optional preferred seat
//   rel_alloc, rel_seat_alloc    release request and seat
//   busy_alloc, done_alloc, fail_alloc, Seat_No_out_alloc  status/result
//   write_mem_alloc, Student_No_mem_alloc, Seat_No_mem_alloc  memory write port
//   occupied_alloc, free_cnt_alloc  occupancy map and free-seat count
module seat_alloc #(
  parameter int unsigned NUM_SEATS = 32,
  parameter int unsigned SEAT_W    = 5,
  parameter int unsigned STU_W     = 25
) (
  input  logic              clk_alloc,
  input  logic              rst_alloc,
  input  logic              req_alloc,
  input  logic [STU_W-1:0]  Student_No_alloc,
  input  logic              pref_en_alloc,
  input  logic [SEAT_W-1:0] pref_seat_alloc,
  input  logic              rel_alloc,
  input  logic [SEAT_W-1:0] rel_seat_alloc,
  output logic              busy_alloc,
  output logic              done_alloc,
  output logic              fail_alloc,
  output logic [SEAT_W-1:0] Seat_No_out_alloc,
  output logic              write_mem_alloc,
  output logic [STU_W-1:0]  Student_No_mem_alloc,
  output logic [SEAT_W-1:0] Seat_No_mem_alloc,
  output logic [NUM_SEATS-1:0] occupied_alloc,
  output logic [SEAT_W:0]   free_cnt_alloc
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_t;

  localparam logic [SEAT_W:0] CNT_FULL = (SEAT_W+1)'(NUM_SEATS);
  localparam logic [SEAT_W:0] CNT_ONE  = (SEAT_W+1)'(1);

  state_t state, state_nxt;

  // Operands captured at acceptance
  logic              op_rel;
  logic [STU_W-1:0]  stu_q;
  logic              pref_en_q;
  logic [SEAT_W-1:0] pref_seat_q;
  logic [SEAT_W-1:0] rel_seat_q;

  logic [NUM_SEATS-1:0] occupied_q;
  logic [SEAT_W:0]      free_cnt_q;
  logic [SEAT_W-1:0]    mem_seat_q;
  logic [STU_W-1:0]     mem_data_q;
  logic [SEAT_W-1:0]    out_seat_q;
  logic                 fail_q;

  logic [SEAT_W-1:0] low_seat;
  logic [SEAT_W-1:0] idx;
  logic              chk_fail;
  logic [SEAT_W-1:0] chk_seat;
  logic [SEAT_W-1:0] fail_seat;

  // Lowest-index free seat: scan from the top so the lowest free index wins.
  always_comb begin
    low_seat = '0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_SEATS; i++) begin
      idx = SEAT_W'(NUM_SEATS - 1 - i);
      if (!occupied_q[idx]) low_seat = idx;
    end
  end

  // Decision made while in CHECK, based on the latched operands
  always_comb begin
    chk_fail  = 1'b0;
    chk_seat  = '0;
    fail_seat = '0;
    if (op_rel) begin
      chk_fail  = !occupied_q[rel_seat_q];
      chk_seat  = rel_seat_q;
      fail_seat = rel_seat_q;
    end else begin
      chk_fail  = (stu_q == '0) || (free_cnt_q == '0);
      chk_seat  = (pref_en_q && !occupied_q[pref_seat_q]) ? pref_seat_q : low_seat;
      fail_seat = pref_en_q ? pref_seat_q : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (rel_alloc || req_alloc) state_nxt = CHECK;
      CHECK: state_nxt = chk_fail ? DONE : WRITE;
      WRITE: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_alloc) begin
    if (rst_alloc) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge clk_alloc) begin
    if (rst_alloc) begin
      op_rel      <= 1'b0;
      stu_q       <= '0;
      pref_en_q   <= 1'b0;
      pref_seat_q <= '0;
      rel_seat_q  <= '0;
      occupied_q  <= '0;
      free_cnt_q  <= CNT_FULL;
      mem_seat_q  <= '0;
      mem_data_q  <= '0;
      out_seat_q  <= '0;
      fail_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rel_alloc || req_alloc) begin
            op_rel      <= rel_alloc;
            stu_q       <= Student_No_alloc;
            pref_en_q   <= pref_en_alloc;
            pref_seat_q <= pref_seat_alloc;
            rel_seat_q  <= rel_seat_alloc;
          end
        end
        CHECK: begin
          fail_q <= chk_fail;
          if (chk_fail) begin
            out_seat_q <= fail_seat;
          end else begin
            mem_seat_q <= chk_seat;
            mem_data_q <= op_rel ? '0 : stu_q;
          end
        end
        WRITE: begin
          occupied_q[mem_seat_q] <= !op_rel;
          free_cnt_q <= op_rel ? free_cnt_q + CNT_ONE : free_cnt_q - CNT_ONE;
          out_seat_q <= mem_seat_q;
        end
        default: ;
      endcase
    end
  end

  assign busy_alloc           = (state != IDLE);
  assign done_alloc           = (state == DONE);
  assign fail_alloc           = (state == DONE) && fail_q;
  assign write_mem_alloc      = (state == WRITE);
  assign Seat_No_out_alloc    = out_seat_q;
  assign Student_No_mem_alloc = mem_data_q;
  assign Seat_No_mem_alloc    = mem_seat_q;
  assign occupied_alloc       = occupied_q;
  assign free_cnt_alloc       = free_cnt_q;

endmodule
